// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with skid entry, flush, hold
// and a saturating squash counter.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 160,
   parameter int unsigned CTRL_W = 24,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   input  logic              hold,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  squash_cnt
);

   localparam bit HAS_SKID = (SKID != 0);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   logic              emit;
   logic [1:0]        sq_n;
   logic [CNT_W+1:0]  cnt_sum;

   // rst gates in_ready so nothing is offered as accepted during reset
   always_comb begin
      if (HAS_SKID)
         in_ready = rst & ~skid_valid_q & ~hold & ~flush;
      else
         in_ready = rst & (~main_valid_q | out_ready) & ~hold & ~flush;
   end

   assign out_valid  = main_valid_q & ~hold;
   assign out_data   = main_data_q;
   assign out_ctrl   = out_valid ? main_ctrl_q : '0;
   assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign squash_cnt = cnt_q;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   always_comb begin
      sq_n    = {1'b0, main_valid_q & ~emit} + {1'b0, skid_valid_q};
      cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, sq_n};
   end

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      cnt_d        = cnt_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_ctrl_d  = '0;
         skid_ctrl_d  = '0;
         if (cnt_sum > {2'b00, CNT_MAX})
            cnt_d = CNT_MAX;
         else
            cnt_d = cnt_sum[CNT_W-1:0];
      end else if (!hold) begin
         if (skid_valid_q) begin
            if (emit) begin
               main_data_d  = skid_data_q;
               main_ctrl_d  = skid_ctrl_q;
               skid_valid_d = 1'b0;
               skid_ctrl_d  = '0;
            end
         end else if (accept && (!main_valid_q || emit)) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
         end else if (accept && HAS_SKID) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
         end else if (emit) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         cnt_q        <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg, plus reset,
// counter saturation and single-entry corner sequences.
module tb_pipe_stage_reg;

   localparam int DW = 160;
   localparam int CW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;
   logic          hold = 1'b0;

   logic          ir1, ov1, ir2, ov2, ir3, ov3;
   logic [DW-1:0] od1, od2, od3;
   logic [CW-1:0] oc1, oc2, oc3;
   logic [1:0]    occ1, occ2, occ3;
   logic [15:0]   cnt1;
   logic [1:0]    cnt2;
   logic [15:0]   cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_ctrl(oc1),
      .flush(flush), .hold(hold),
      .occupancy(occ1), .squash_cnt(cnt1)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir2),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_ctrl(oc2),
      .flush(flush), .hold(hold),
      .occupancy(occ2), .squash_cnt(cnt2)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_nsk (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir3),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov3), .out_ready(out_ready),
      .out_data(od3), .out_ctrl(oc3),
      .flush(flush), .hold(hold),
      .occupancy(occ3), .squash_cnt(cnt3)
   );

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic [7:0] c;
      logic       ordy;
      logic       fl;
      logic       hd;
      logic       ov;
      logic [7:0] od;
      logic [7:0] oc;
      logic       ir;
      logic [1:0] occ;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic iv, input logic [7:0] d,
                      input logic [7:0] c, input logic ordy,
                      input logic fl, input logic hd,
                      input logic ov, input logic [7:0] od,
                      input logic [7:0] oc, input logic ir,
                      input logic [1:0] occ, input logic [15:0] cnt);
      vec_t v;
      v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
      v.fl = fl; v.hd = hd; v.ov = ov; v.od = od;
      v.oc = oc; v.ir = ir; v.occ = occ; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [7:0] d,
                       input logic [7:0] c, input logic ordy,
                       input logic fl, input logic hd);
      @(negedge clk);
      in_valid  = iv;
      in_data   = DW'(d);
      in_ctrl   = CW'(c);
      out_ready = ordy;
      flush     = fl;
      hold      = hd;
      #1;
   endtask

   initial begin
      // passthrough
      add(1, 8'h01, 8'h0A, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      for (int k = 1; k <= 7; k++)
         add(1, 8'(k + 1), 8'h0A, 1, 0, 0, 1, 8'(k), 8'h0A, 1, 1, 0);
      add(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h08, 8'h0A, 1, 1, 0);
      // backpressure
      add(1, 8'hA1, 8'h11, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      add(1, 8'hB2, 8'h22, 0, 0, 0, 1, 8'hA1, 8'h11, 1, 1, 0);
      add(1, 8'hC3, 8'h3C, 0, 0, 0, 1, 8'hA1, 8'h11, 0, 2, 0);
      add(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'hA1, 8'h11, 0, 2, 0);
      add(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'hB2, 8'h22, 1, 1, 0);
      // flush with two entries, flush-cycle input dropped
      add(1, 8'hD4, 8'h33, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      add(1, 8'hE5, 8'h44, 0, 0, 0, 1, 8'hD4, 8'h33, 1, 1, 0);
      add(1, 8'hF6, 8'h55, 0, 1, 0, 1, 8'hD4, 8'h33, 0, 2, 0);
      add(0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 2);
      // hold
      add(1, 8'hC7, 8'h66, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 2);
      for (int k = 0; k < 3; k++)
         add(1, 8'h99, 8'h77, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 2);
      add(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'hC7, 8'h66, 1, 1, 2);
      add(0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 2);
      // flush while emitting is not counted
      add(1, 8'h10, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 2);
      add(0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h10, 8'h01, 0, 1, 2);
      add(0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 2);

      // reset state
      in_valid = 1'b1;
      #3;
      chk("rst_out_valid", DW'(ov1), DW'(0));
      chk("rst_out_data", od1, DW'(0));
      chk("rst_out_ctrl", DW'(oc1), DW'(0));
      chk("rst_in_ready", DW'(ir1), DW'(0));
      chk("rst_occ", DW'(occ1), DW'(0));
      chk("rst_cnt", DW'(cnt1), DW'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].c,
              tbl[i].ordy, tbl[i].fl, tbl[i].hd);
         chk($sformatf("v%0d_out_valid", i), DW'(ov1), DW'(tbl[i].ov));
         chk($sformatf("v%0d_out_ctrl", i), DW'(oc1), DW'(tbl[i].oc));
         chk($sformatf("v%0d_in_ready", i), DW'(ir1), DW'(tbl[i].ir));
         chk($sformatf("v%0d_occ", i), DW'(occ1), DW'(tbl[i].occ));
         chk($sformatf("v%0d_cnt", i), DW'(cnt1), DW'(tbl[i].cnt));
         if (tbl[i].ov)
            chk($sformatf("v%0d_out_data", i), od1, DW'(tbl[i].od));
      end

      // build squash_cnt=5 and occupancy=2, then reset mid-cycle
      step(1, 8'h21, 8'h01, 0, 0, 0);
      step(1, 8'h22, 8'h02, 0, 0, 0);
      step(0, 8'h00, 8'h00, 0, 1, 0);
      step(0, 8'h00, 8'h00, 0, 0, 0);
      chk("cnt_four", DW'(cnt1), DW'(4));
      step(1, 8'h23, 8'h03, 0, 0, 0);
      step(0, 8'h00, 8'h00, 0, 1, 0);
      step(0, 8'h00, 8'h00, 0, 0, 0);
      chk("cnt_five", DW'(cnt1), DW'(5));
      step(1, 8'h24, 8'h04, 0, 0, 0);
      step(1, 8'h25, 8'h05, 0, 0, 0);
      step(0, 8'h00, 8'h00, 1, 0, 0);
      chk("pre_rst_occ", DW'(occ1), DW'(2));
      chk("pre_rst_ov", DW'(ov1), DW'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_ov", DW'(ov1), DW'(0));
      chk("mid_rst_ctrl", DW'(oc1), DW'(0));
      chk("mid_rst_occ", DW'(occ1), DW'(0));
      chk("mid_rst_cnt", DW'(cnt1), DW'(0));
      chk("mid_rst_ir", DW'(ir1), DW'(0));
      @(negedge clk);
      rst = 1'b1;

      // saturation on the 2-bit counter
      for (int n = 0; n < 5; n++) begin
         step(1, 8'h40, 8'h08, 0, 0, 0);
         step(0, 8'h00, 8'h00, 0, 1, 0);
         if (n == 2) begin
            step(0, 8'h00, 8'h00, 0, 0, 0);
            chk("sat_cnt_three", DW'(cnt2), DW'(3));
         end
      end
      step(0, 8'h00, 8'h00, 0, 0, 0);
      chk("sat_cnt_hold", DW'(cnt2), DW'(3));
      chk("wide_cnt_five", DW'(cnt1), DW'(5));

      // single-entry stage under backpressure
      step(1, 8'h31, 8'h09, 0, 0, 0);
      chk("nsk_ir_empty", DW'(ir3), DW'(1));
      chk("nsk_occ_empty", DW'(occ3), DW'(0));
      step(1, 8'h32, 8'h0A, 0, 0, 0);
      chk("nsk_ir_full", DW'(ir3), DW'(0));
      chk("nsk_occ_full", DW'(occ3), DW'(1));
      chk("nsk_data_x", od3, DW'(8'h31));
      step(1, 8'h32, 8'h0A, 0, 0, 0);
      chk("nsk_ir_full2", DW'(ir3), DW'(0));
      chk("nsk_occ_full2", DW'(occ3), DW'(1));
      step(1, 8'h32, 8'h0A, 1, 0, 0);
      chk("nsk_ir_drain", DW'(ir3), DW'(1));
      chk("nsk_ov_drain", DW'(ov3), DW'(1));
      chk("nsk_data_drain", od3, DW'(8'h31));
      step(0, 8'h00, 8'h00, 1, 0, 0);
      chk("nsk_data_y", od3, DW'(8'h32));
      chk("nsk_ctrl_y", DW'(oc3), DW'(8'h0A));
      chk("nsk_occ_y", DW'(occ3), DW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register: the next generation of the fixed-field ID/EX-style latch.
- Payload splits into a DATA field (operands, immediates, PC) and a CTRL field (enables, mux selects, ALU op). Bubble insertion zeroes CTRL, which is a NOP in every stage.
- Adds a valid/ready handshake and an optional skid entry for full throughput under backpressure.
- Adds a flush that squashes in-flight entries, a freeze input compatible with the old stall, and a squash counter.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 160: width of the data payload.
- CTRL_W, 24: width of the control payload; zeroed on bubble, flush and reset.
- SKID, 1: 1 adds a second (skid) entry with registered in_ready; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: width of the saturating squash counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream holds a valid entry.
- in_ready, output, 1: stage accepts an entry this cycle.
- in_data, input, DATA_W: upstream data payload.
- in_ctrl, input, CTRL_W: upstream control payload.
- out_valid, output, 1: stage presents a valid entry.
- out_ready, input, 1: downstream accepts the entry this cycle.
- out_data, output, DATA_W: data payload of the head entry.
- out_ctrl, output, CTRL_W: control payload of the head entry; all-zero when out_valid=0.
- flush, input, 1: squash all held entries (branch/exception redirect).
- hold, input, 1: freeze the stage (legacy stall).
- occupancy, output, 2: number of held entries (0..2).
- squash_cnt, output, CNT_W: saturating count of entries discarded by flush.

Behaviour:
- Reset (rst=0, asynchronous):
  - main_valid=0, skid_valid=0.
  - All stored data and ctrl=0, squash_cnt=0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 while rst=0.
  - Reset mid-transfer drops all entries and does not count them.
- Definitions: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Priority, highest first: flush, then hold, then the normal handshake.
- flush=1:
  - Next cycle main_valid=0, skid_valid=0, stored ctrl of both entries=0; stored data is retained but is don't-care.
  - in_ready=0 combinationally, so no accept occurs; out_valid is still driven, and an emit in the flush cycle is legal and is not counted.
  - squash_cnt += (main_valid & ~emit) + skid_valid, saturating at all-ones.
- hold=1 (with flush=0):
  - in_ready=0 and out_valid=0 combinationally.
  - No state change.
  - Valid may drop under hold; downstream treats this as a bubble.
- States (SKID=1), driven by {skid_valid, main_valid}:
  - EMPTY: accept -> FULL, main<=in.
  - FULL:
    - accept & emit -> FULL, main<=in.
    - emit only -> EMPTY, main ctrl<=0.
    - accept only -> SKID, skid<=in.
  - SKID: in_ready=0; emit -> FULL, main<=skid, skid ctrl<=0.
  - in_ready = ~skid_valid & ~hold & ~flush, from a registered term.
- SKID=0:
  - No skid entry.
  - in_ready = (~main_valid | out_ready) & ~hold & ~flush, so the SKID state is unreachable.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - Sustains 1 entry/cycle when out_ready=1.
  - Entries leave in arrival order; none are lost or duplicated except by flush.
- Output ordering: out_data/out_ctrl always come from main; skid is never presented directly.
- occupancy = main_valid + skid_valid.
- Counter: squash_cnt never wraps; it stays at 2^CNT_W-1 once reached and is cleared only by reset.

Test Plan:
- Passthrough: SKID=1, out_ready=1, push data 1..8 with ctrl=0x00000A on consecutive cycles -> out_valid one cycle after each accept, data 1..8 in order, in_ready stays 1, occupancy≤1.
- Backpressure: push A,B with out_ready=0 -> occupancy=2, in_ready=0. Raise out_ready -> A then B on consecutive cycles, in_ready returns 1 the cycle after A leaves.
- Flush with 2 entries: fill both, assert flush 1 cycle with in_valid=1 -> next cycle occupancy=0, out_ctrl=0, squash_cnt=2, and the flush-cycle input is not accepted.
- Hold: FULL with entry C, hold=1 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, C emitted on the first cycle after hold drops.
- Reset mid-operation: occupancy=2, squash_cnt=5, drive rst=0 between clock edges -> immediately out_valid=0, out_ctrl=0, occupancy=0, squash_cnt=0.
- Saturation and SKID=0: with CNT_W=2, perform 5 single-entry flushes -> squash_cnt=3. With SKID=0 and out_ready=0 while full -> in_ready=0, occupancy never exceeds 1.
